// File: rtl/helios_link_pkg.sv
// rtl/helios_link_pkg.sv - shared link constants and arbiter state type
package helios_link_pkg;

  localparam int LINK_W        = 64;
  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_LEN_WIDTH = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin priority picker
module rr_select #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] winner,
  output logic         any
);

  function automatic logic [W-1:0] idx_of(input logic [W-1:0] base, input int k);
    return W'((int'(base) + k) % N);
  endfunction

  // Scan offsets from farthest to nearest so the requester closest to ptr is assigned last and wins
  always_comb begin
    winner = '0;
    any    = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[idx_of(ptr, k)]) winner = idx_of(ptr, k);
    end
  end

endmodule

// File: rtl/leaf_uplink_arbiter.sv
// rtl/leaf_uplink_arbiter.sv - message-aware round-robin merge of leaf links into the root port
module leaf_uplink_arbiter
  import helios_link_pkg::*;
#(
  parameter int NUM_LEAVES = 4,
  parameter int LEN_LSB    = HDR_LEN_LSB,
  parameter int LEN_WIDTH  = HDR_LEN_WIDTH,
  parameter int SRC_W      = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [LINK_W*NUM_LEAVES-1:0] leaf_tx_data,
  input  logic [NUM_LEAVES-1:0]        leaf_tx_valid,
  output logic [NUM_LEAVES-1:0]        leaf_tx_ready,
  output logic [LINK_W-1:0]            root_rx_data,
  output logic                         root_rx_valid,
  input  logic                         root_rx_ready,
  output logic [SRC_W-1:0]             root_rx_src,
  output logic                         root_rx_last,
  output logic                         busy
);

  arb_state_t           state;
  logic [SRC_W-1:0]     grant;
  logic [SRC_W-1:0]     rr_ptr;
  logic [SRC_W-1:0]     winner;
  logic [SRC_W-1:0]     sel;
  logic [SRC_W-1:0]     rr_next;
  logic [LEN_WIDTH-1:0] remaining;
  logic [LEN_WIDTH-1:0] hdr_len;
  logic [LINK_W-1:0]    in_data;
  logic                 any_req;
  logic                 slot_free;
  logic                 in_fire;
  logic                 in_last;

  rr_select #(
    .N (NUM_LEAVES),
    .W (SRC_W)
  ) u_rr_select (
    .req    (leaf_tx_valid),
    .ptr    (rr_ptr),
    .winner (winner),
    .any    (any_req)
  );

  assign slot_free = !root_rx_valid || root_rx_ready;
  assign sel       = (state == IDLE) ? winner : grant;
  assign hdr_len   = in_data[LEN_LSB +: LEN_WIDTH];
  assign in_last   = (state == IDLE) ? (hdr_len == '0) : (remaining == LEN_WIDTH'(1));
  assign rr_next   = (sel == SRC_W'(NUM_LEAVES - 1)) ? '0 : sel + 1'b1;
  assign in_fire   = |(leaf_tx_ready & leaf_tx_valid);
  assign busy      = (state == XFER);

  // Route the selected leaf's beat in and open only that leaf's ready when the output slot can take it
  always_comb begin
    leaf_tx_ready = '0;
    in_data       = '0;
    for (int i = 0; i < NUM_LEAVES; i++) begin
      if (SRC_W'(i) == sel) begin
        in_data          = leaf_tx_data[LINK_W*i +: LINK_W];
        leaf_tx_ready[i] = !reset && slot_free && ((state == XFER) || any_req);
      end
    end
  end

  // One-entry output register: load on any accepted beat, otherwise drain when the root takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      root_rx_valid <= 1'b0;
      root_rx_data  <= '0;
      root_rx_src   <= '0;
      root_rx_last  <= 1'b0;
    end else if (in_fire) begin
      root_rx_valid <= 1'b1;
      root_rx_data  <= in_data;
      root_rx_src   <= sel;
      root_rx_last  <= in_last;
    end else if (root_rx_ready) begin
      root_rx_valid <= 1'b0;
    end
  end

  // Message tracking: lock the grant for a whole message, advance the pointer when it completes
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      remaining <= '0;
      rr_ptr    <= '0;
    end else if (in_fire) begin
      case (state)
        IDLE: begin
          remaining <= hdr_len;
          if (hdr_len != '0) begin
            grant <= sel;
            state <= XFER;
          end else begin
            rr_ptr <= rr_next;
          end
        end
        XFER: begin
          remaining <= remaining - LEN_WIDTH'(1);
          if (remaining == LEN_WIDTH'(1)) begin
            rr_ptr <= rr_next;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_leaf_uplink_arbiter.sv
// tb/tb_leaf_uplink_arbiter.sv - randomized scoreboard bench for leaf_uplink_arbiter
module tb_leaf_uplink_arbiter;

  localparam int N  = 4;
  localparam int SW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [64*N-1:0] leaf_tx_data;
  logic [N-1:0]    leaf_tx_valid;
  logic [N-1:0]    leaf_tx_ready;
  logic [63:0]     root_rx_data;
  logic            root_rx_valid;
  logic            root_rx_ready;
  logic [SW-1:0]   root_rx_src;
  logic            root_rx_last;
  logic            busy;

  leaf_uplink_arbiter #(.NUM_LEAVES(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .leaf_tx_data  (leaf_tx_data),
    .leaf_tx_valid (leaf_tx_valid),
    .leaf_tx_ready (leaf_tx_ready),
    .root_rx_data  (root_rx_data),
    .root_rx_valid (root_rx_valid),
    .root_rx_ready (root_rx_ready),
    .root_rx_src   (root_rx_src),
    .root_rx_last  (root_rx_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0]   data;
    logic [SW-1:0] src;
    logic          last;
  } beat_t;

  beat_t       sb[$];
  logic [63:0] lq[N][$];
  int          lc[N];
  int          checks = 0;
  int          failures = 0;

  bit          m_busy, m_ov;
  int          m_owner, m_left, m_ptr;

  int          vpct, rpct;
  logic [N-1:0] hold;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add_msg(input int leaf, input int len);
    logic [63:0] h;
    h = {$urandom, $urandom};
    h[7:0] = len[7:0];
    lq[leaf].push_back(h);
    for (int k = 0; k < len; k++) lq[leaf].push_back({$urandom, $urandom});
  endtask

  function automatic bit queued();
    bit q = 0;
    for (int i = 0; i < N; i++) if (lq[i].size() > 0) q = 1;
    return q;
  endfunction

  task automatic model_reset();
    sb.delete();
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < lc[i]; k++) void'(lq[i].pop_front());
      lc[i] = 0;
    end
    m_busy = 0; m_ov = 0; m_owner = 0; m_left = 0; m_ptr = 0;
  endtask

  // One clock cycle: drive inputs, check ready/valid/busy against the model, then advance the model
  task automatic step(input bit rst);
    logic [N-1:0] pr;
    logic [63:0]  d;
    int           w, len;
    bit           free, last;
    @(negedge clk);
    reset = rst;
    root_rx_ready = rst ? 1'b0 : ($urandom_range(0, 99) < rpct);
    for (int i = 0; i < N; i++) begin
      leaf_tx_valid[i] = (lq[i].size() > 0) && !hold[i] && ($urandom_range(0, 99) < vpct);
      leaf_tx_data[64*i +: 64] = (lq[i].size() > 0) ? lq[i][0] : 64'h0;
    end
    #1;
    chk("root_valid", root_rx_valid, m_ov);
    chk("busy", busy, m_busy);
    pr = '0;
    w = -1;
    free = !m_ov || root_rx_ready;
    if (!rst) begin
      if (m_busy) w = m_owner;
      else
        for (int k = 0; k < N; k++)
          if (w < 0 && leaf_tx_valid[SW'((m_ptr + k) % N)]) w = (m_ptr + k) % N;
      if (w >= 0 && free) pr[SW'(w)] = 1'b1;
    end
    chk("leaf_ready", leaf_tx_ready, pr);
    if (rst) begin
      model_reset();
    end else if (w >= 0 && free && leaf_tx_valid[SW'(w)]) begin
      d = lq[w].pop_front();
      if (!m_busy) begin
        len = int'(d[7:0]);
        lc[w] = len;
        last = (len == 0);
        if (len == 0) m_ptr = (w + 1) % N;
        else begin
          m_busy = 1; m_owner = w; m_left = len;
        end
      end else begin
        m_left--;
        lc[w]--;
        last = (m_left == 0);
        if (last) begin
          m_busy = 0;
          m_ptr = (w + 1) % N;
        end
      end
      sb.push_back(beat_t'({d, SW'(w), last}));
      m_ov = 1;
    end else if (root_rx_ready) begin
      m_ov = 0;
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    vpct = 100; rpct = 100; hold = '0;
    while ((queued() || sb.size() > 0 || m_ov) && n < 2000) begin
      step(0);
      n++;
    end
    checks++;
    if (n >= 2000) begin
      failures++;
      $display("FAIL drain_%s timeout remaining_beats=%0d", name, sb.size());
    end
  endtask

  task automatic reset_checks(input string name);
    @(posedge clk);
    #1;
    chk({name, "_valid"}, root_rx_valid, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_data"}, root_rx_data, 0);
    chk({name, "_src"}, root_rx_src, 0);
    chk({name, "_last"}, root_rx_last, 0);
    chk({name, "_rr_ptr"}, dut.rr_ptr, 0);
  endtask

  // Monitor: every root handshake pops the oldest expected beat and compares it
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!reset && root_rx_valid && root_rx_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual_data=%0h expected=none", root_rx_data);
        end else begin
          e = sb.pop_front();
          chk("out_data", root_rx_data, e.data);
          chk("out_src", root_rx_src, e.src);
          chk("out_last", root_rx_last, e.last);
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    root_rx_ready = 1'b0;
    leaf_tx_valid = '0;
    leaf_tx_data = '0;
    hold = '0;
    vpct = 100;
    rpct = 100;
    for (int i = 0; i < N; i++) lc[i] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    step(1);
    reset_checks("reset");

    // single leaf: leaf 2, LEN=3
    add_msg(2, 3);
    drain("single");
    chk("single_rr_ptr", dut.rr_ptr, 3);

    // contention: leaves 0,1,3 with LEN=1 from reset
    step(1);
    reset_checks("reset2");
    add_msg(0, 1); add_msg(1, 1); add_msg(3, 1);
    drain("contention");

    // zero-length burst on all leaves
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) add_msg(i, 0);
    drain("zero_len");

    // backpressure mid-message
    add_msg(1, 6);
    vpct = 100; rpct = 100;
    repeat (3) step(0);
    rpct = 0;
    repeat (5) step(0);
    drain("backpressure");

    // granted-leaf stall: leaf 1 holds the grant while leaf 0 waits
    add_msg(1, 4); add_msg(0, 2);
    vpct = 100; rpct = 100;
    hold = 4'b0001;
    repeat (2) step(0);
    hold = 4'b0010;
    repeat (3) step(0);
    drain("stall");

    // reset after 2 of 5 beats
    add_msg(2, 4); add_msg(1, 1); add_msg(3, 0);
    hold = 4'b1010;
    repeat (2) step(0);
    hold = '0;
    step(1);
    reset_checks("reset_mid");
    drain("after_reset");

    // randomized traffic with backpressure, gaps and occasional resets
    vpct = 70; rpct = 70;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) add_msg($urandom_range(0, N - 1), $urandom_range(0, 5));
      step($urandom_range(0, 299) == 0);
    end
    drain("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
